// File: rtl/raid_flash_arbiter.sv
// raid_flash_arbiter
// Owns the shared SPI flash command engine and hands it to one of three
// requesters at a time (main host, secondary host, management port). Applies
// the RAID-1 policy when a grant is issued: writes go to every healthy flash,
// reads go to one healthy flash, and the transaction is refused when neither
// flash is healthy.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   req[2:0]        level requests: bit0 main host, bit1 secondary, bit2 mgmt
//   req_write[2:0]  per-requester write flag, valid with its req bit
//   sh_lockout      secondary host ineligible while high
//   mf_fault        main flash marked failed
//   sf_fault        secondary flash marked failed
//   eng_done        engine finished the transaction (pulse)
//   gnt[2:0]        one-hot grant, same bit order as req
//   eng_start       start pulse toward the engine
//   eng_abort       abort pulse toward the engine
//   eng_write       granted transaction is a write (held with gnt)
//   eng_sel[1:0]    flash mask, bit0 main, bit1 secondary (held with gnt)
//   timeout         watchdog expiry pulse
//   nodev           transaction refused pulse (no healthy flash)
//   busy            high whenever the arbiter is not idle
module raid_flash_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int RD_PREF        = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] req_write,
    input  logic       sh_lockout,
    input  logic       mf_fault,
    input  logic       sf_fault,
    input  logic       eng_done,
    output logic [2:0] gnt,
    output logic       eng_start,
    output logic       eng_abort,
    output logic       eng_write,
    output logic [1:0] eng_sel,
    output logic       timeout,
    output logic       nodev,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_wd;
    logic        r_rr_last;
    logic [2:0]  r_gnt;
    logic        r_start;
    logic        r_abort;
    logic        r_write;
    logic [1:0]  r_sel;
    logic        r_timeout;
    logic        r_nodev;

    logic [2:0]  w_elig;
    logic [2:0]  w_win;
    logic [1:0]  w_sel;
    logic        w_gnt_req;

    assign w_elig    = {req[2], req[1] & ~sh_lockout, req[0]};
    // Granted requester still holding its request (host CS_n still low).
    assign w_gnt_req = |(req & r_gnt);

    // Winner selection: management first, then round-robin between hosts
    // where the host that did not win last time takes a tie.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_win = 3'b000;
        if (w_elig[2]) begin
            w_win = 3'b100;
        end else if (w_elig[1] && w_elig[0]) begin
            w_win = r_rr_last ? 3'b001 : 3'b010;
        end else if (w_elig[0]) begin
            w_win = 3'b001;
        end else if (w_elig[1]) begin
            w_win = 3'b010;
        end
    end

    // Flash mask for the pending grant; only used when a flash is healthy.
    always_comb begin
        w_sel = 2'b00;
        if (|(req_write & w_win)) begin
            w_sel = {~sf_fault, ~mf_fault};
        end else if (RD_PREF == 0) begin
            w_sel = mf_fault ? 2'b10 : 2'b01;
        end else begin
            w_sel = sf_fault ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wd      <= '0;
            r_rr_last <= 1'b1;
            r_gnt     <= '0;
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_write   <= 1'b0;
            r_sel     <= '0;
            r_timeout <= 1'b0;
            r_nodev   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values; the pulse defaults below
            // are safely overridden by later assignments in the same block.
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_timeout <= 1'b0;
            r_nodev   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_gnt   <= w_win;
                        r_write <= |(req_write & w_win);
                        r_wd    <= '0;
                        if (|w_win[1:0]) begin
                            r_rr_last <= w_win[1];
                        end
                        if (mf_fault && sf_fault) begin
                            r_sel   <= 2'b00;
                            r_nodev <= 1'b1;
                            r_state <= ST_RELEASE;
                        end else begin
                            r_sel   <= w_sel;
                            r_start <= 1'b1;
                            r_state <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // eng_done outranks both watchdog expiry and request drop.
                    if (eng_done) begin
                        r_state <= ST_RELEASE;
                    end else if (r_wd == WD_LAST) begin
                        r_timeout <= 1'b1;
                        r_abort   <= 1'b1;
                        r_state   <= ST_RELEASE;
                    end else if (!w_gnt_req) begin
                        r_abort <= 1'b1;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!w_gnt_req) begin
                        r_gnt   <= '0;
                        r_write <= 1'b0;
                        r_sel   <= '0;
                        r_wd    <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign eng_start = r_start;
    assign eng_abort = r_abort;
    assign eng_write = r_write;
    assign eng_sel   = r_sel;
    assign timeout   = r_timeout;
    assign nodev     = r_nodev;
    assign busy      = (r_state != ST_IDLE);

endmodule
